// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and a zeroing init sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  mark,
    input  logic [ADDR_W-1:0]     maddr,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                rdy_q;
    logic [DEPTH-1:0]    busy;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic wr_ok;
    logic mk_ok;

    assign wr_ok = we & (waddr != '0);
    assign mk_ok = mark & (maddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    busy[cnt] <= 1'b0;
                    if (cnt == '1) begin
                        state <= READY;
                        rdy_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    // Set after clear so a same-cycle mark wins.
                    if (wr_ok) busy[waddr] <= 1'b0;
                    if (mk_ok) busy[maddr] <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[cnt] <= '0;
            else if (wr_ok)
                mem[waddr] <= wdata;
        end
    end

    assign ready = rdy_q & ~rst;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              act;
        logic              byp;

        assign ra  = raddr[k*ADDR_W +: ADDR_W];
        assign act = re[k] & ready & (ra != '0);

`ifdef REGFILE_BYPASS_EN
        assign byp = act & we & (waddr == ra);
`else
        assign byp = 1'b0;
`endif

        assign rdata[k*DATA_W +: DATA_W] =
            !act ? '0 : (byp ? wdata : mem[ra]);

        assign rbusy[k] =
            act & (byp ? (mark & (maddr == waddr)) : busy[ra]);
    end

endmodule
